// File: rtl/adder_pipe.sv
// Pipelined two's-complement adder/subtractor.
// Operands are split into STAGES chunks with a carry registered between chunks.
module adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             V
);

    localparam int CHUNK = WIDTH / STAGES;

    // vld[k] qualifies the data held in the stage-k registers;
    // vld[STAGES] is the output register.
    logic [STAGES:0]  vld;
    logic [WIDTH-1:0] a_q [STAGES+1];
    logic [WIDTH-1:0] b_q [STAGES+1];
    logic [WIDTH-1:0] s_q [STAGES+1];
    logic             c_q [STAGES+1];
    logic             ovf_q;
    logic [CHUNK:0]   sum_c [STAGES];

    // Per-stage chunk adder: chunk k of the skewed operands plus the
    // carry registered by the previous stage.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            sum_c[k] = {1'b0, a_q[k][k*CHUNK +: CHUNK]}
                     + {1'b0, b_q[k][k*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, c_q[k]};
        end
    end

    // Pipeline registers: the entry stage captures the effective operands,
    // each later stage forwards the operands (skew), the partial sum (deskew)
    // and its carry; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld          <= '0;
            s_q[STAGES]  <= '0;
            c_q[STAGES]  <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (!stall) begin
            vld <= {vld[STAGES-1:0], in_valid};
            if (in_valid) begin
                a_q[0] <= A;
                b_q[0] <= B ^ {WIDTH{sub}};
                s_q[0] <= '0;
                c_q[0] <= Ci ^ sub;
            end
            for (int k = 0; k < STAGES; k++) begin
                if (vld[k]) begin
                    a_q[k+1]                   <= a_q[k];
                    b_q[k+1]                   <= b_q[k];
                    s_q[k+1]                   <= s_q[k];
                    s_q[k+1][k*CHUNK +: CHUNK] <= sum_c[k][CHUNK-1:0];
                    c_q[k+1]                   <= sum_c[k][CHUNK];
                end
            end
            // Carry into the MSB is recovered as a^b^s at that bit.
            if (vld[STAGES-1]) begin
                ovf_q <= a_q[STAGES-1][WIDTH-1]
                       ^ b_q[STAGES-1][WIDTH-1]
                       ^ sum_c[STAGES-1][CHUNK-1]
                       ^ sum_c[STAGES-1][CHUNK];
            end
        end
    end

    assign out_valid = vld[STAGES];
    assign S         = s_q[STAGES];
    assign Co        = c_q[STAGES];
    assign V         = ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Testbench for adder_pipe (WIDTH=16, STAGES=4).
// Directed table vectors, stall/reset sequences and a random stream vs. a model.
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        Ci;
    logic        stall;
    logic        out_valid;
    logic [15:0] S;
    logic        Co;
    logic        V;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int popped      = 0;
    int last_cyc    = 0;

    logic [17:0] expq [$];

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        v;
    } vec_t;

    vec_t tbl [8];

    adder_pipe #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .sub(sub),
        .A(A), .B(B), .Ci(Ci), .stall(stall),
        .out_valid(out_valid), .S(S), .Co(Co), .V(V)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: integer arithmetic, borrow/overflow judged from true results.
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        int ua, ub, sa, sbv, u, sr;
        logic [15:0] s;
        logic co, v;
        ua  = int'(a);
        ub  = int'(b);
        sa  = int'($signed(a));
        sbv = int'($signed(b));
        if (sb) begin
            u  = ua - ub - int'(ci);
            sr = sa - sbv - int'(ci);
            co = (u >= 0);
        end else begin
            u  = ua + ub + int'(ci);
            sr = sa + sbv + int'(ci);
            co = (u > 65535);
        end
        s = u[15:0];
        v = (sr > 32767) || (sr < -32768);
        return {s, co, v};
    endfunction

    // Scoreboard: accept on unstalled in_valid, consume on unstalled out_valid.
    always @(negedge clk) begin
        logic [17:0] e;
        if (reset === 1'b1) begin
            expq.delete();
        end else begin
            if (out_valid === 1'b1 && stall === 1'b0) begin
                if (expq.size() == 0) begin
                    chk("unexpected out_valid", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk("stream S/Co/V", {S, Co, V}, e);
                end
                popped++;
                last_cyc = cyc;
            end
            if (in_valid === 1'b1 && stall === 1'b0)
                expq.push_back(model(A, B, Ci, sub));
        end
    end

    task automatic drv(input logic iv, input logic st, input logic rs,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb);
        @(posedge clk);
        #1;
        in_valid = iv;
        stall    = st;
        reset    = rs;
        A        = a;
        B        = b;
        Ci       = ci;
        sub      = sb;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        drv(1'b1, 1'b0, 1'b0, v.a, v.b, v.ci, v.sb);
        idle();
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (out_valid !== 1'b1 && lat < 10);
        chk($sformatf("vec%0d latency", idx), lat, 4);
        chk($sformatf("vec%0d S", idx), S, v.s);
        chk($sformatf("vec%0d Co", idx), Co, v.co);
        chk($sformatf("vec%0d V", idx), V, v.v);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d pulse", idx), out_valid, 0);
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, " out_valid"}, out_valid, 0);
        chk({nm, " S"}, S, 0);
        chk({nm, " Co"}, Co, 0);
        chk({nm, " V"}, V, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] oa [6];
        logic [15:0] ob [6];
        logic        oc [6];
        logic        os [6];
        logic [17:0] fe;
        int e, p0;

        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset held for two edges with random inputs, then four idle cycles.
        reset    = 1'b1;
        in_valid = 1'($urandom);
        stall    = 1'($urandom);
        A        = 16'($urandom);
        B        = 16'($urandom);
        Ci       = 1'($urandom);
        sub      = 1'($urandom);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_reset_state("reset hold");
            #1;
            in_valid = (i == 0) ? 1'($urandom) : 1'b0;
            stall    = (i == 0) ? 1'($urandom) : 1'b0;
            reset    = (i == 0);
            A        = 16'($urandom);
            B        = 16'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_reset_state("after reset");
        end

        // Directed vectors.
        for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

        // Result frozen by a 2-cycle stall while out_valid is high.
        fe = model(16'hA5A5, 16'h1357, 1'b1, 1'b0);
        drv(1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h1357, 1'b1, 1'b0);
        repeat (4) idle();
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, (i < 2), 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
            @(negedge clk);
            chk("freeze out_valid", out_valid, 1);
            chk("freeze S/Co/V", {S, Co, V}, fe);
        end
        idle();
        @(negedge clk);
        chk("freeze consumed", out_valid, 0);
        chk("hold S/Co/V", {S, Co, V}, fe);
        repeat (2) idle();

        // Six back-to-back operations with a 2-cycle stall after the third.
        for (int i = 0; i < 6; i++) begin
            oa[i] = 16'($urandom);
            ob[i] = 16'($urandom);
            oc[i] = 1'($urandom);
            os[i] = 1'($urandom);
        end
        p0 = popped;
        drv(1'b1, 1'b0, 1'b0, oa[0], ob[0], oc[0], os[0]);
        e = cyc + 1;
        drv(1'b1, 1'b0, 1'b0, oa[1], ob[1], oc[1], os[1]);
        drv(1'b1, 1'b0, 1'b0, oa[2], ob[2], oc[2], os[2]);
        drv(1'b1, 1'b1, 1'b0, oa[3], ob[3], oc[3], os[3]);
        drv(1'b1, 1'b1, 1'b0, oa[3], ob[3], oc[3], os[3]);
        for (int i = 3; i < 6; i++)
            drv(1'b1, 1'b0, 1'b0, oa[i], ob[i], oc[i], os[i]);
        idle();
        for (int k = 0; k < 30 && popped < p0 + 6; k++) @(posedge clk);
        chk("stream count", popped - p0, 6);
        chk("stream span", last_cyc - e + 1, 12);

        // Reset one cycle after three issued operations.
        for (int i = 0; i < 3; i++)
            drv(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        drv(1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midflight reset out_valid", out_valid, 0);
        end
        run_vec(tbl[6], 6);

        // Random stream with random stalls, then drain.
        for (int i = 0; i < 300; i++)
            drv(($urandom % 4) != 0, ($urandom % 5) == 0, 1'b0,
                16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        repeat (10) idle();
        @(negedge clk);
        chk("drain queue empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
